alu16_sequencer: RTL and testbench

Micro-operation sequencer that sits directly upstream of the 16-bit ALU datapath (operand registers, 74181-style adder array, result register). It accepts one operation per START, drives the ALU operand buses and function-select lines, and generates the three register load strobes (CPR0/CPR1/CPR2) in a fixed order. It then samples the ALU result into a local holding register and returns it with a ZERO flag and a one-cycle DONE pulse.

---
 rtl/alu16_sequencer_if.sv | 49 ++++
 rtl/alu16_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_alu16_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu16_sequencer_if.sv
// alu16_sequencer_if: bundles the request, ALU-control and status signals
// of the 16-bit ALU micro-operation sequencer.
//
// Handshake: a request is START together with OP/OPA/OPB. It is taken on a
// rising CLK edge only while BUSY is low. While BUSY is high, START is
// ignored. Every taken request ends with exactly one cycle of DONE.
// RESULT, ZERO, ERR and OVF are valid in that DONE cycle and hold afterwards.
// START may be high during the DONE cycle. In that case the next request is
// taken on the following edge.
//
// master: requester and ALU datapath (drives the request and Q).
// slave : the sequencer itself.
interface alu16_sequencer_if;
    logic        START;
    logic [3:0]  OP;
    logic [15:0] OPA;
    logic [15:0] OPB;
    logic [15:0] Q;
    logic [15:0] A;
    logic [15:0] B;
    logic        CPR0;
    logic        CPR1;
    logic        CPR2;
    logic        S3;
    logic        S2;
    logic        S1;
    logic        S0;
    logic        M;
    logic        CN;
    logic [15:0] RESULT;
    logic        ZERO;
    logic        ERR;
    logic        BUSY;
    logic        DONE;
    logic        OVF;
    logic [2:0]  dbg_state;

    modport master (
        output START, OP, OPA, OPB, Q,
        input  A, B, CPR0, CPR1, CPR2, S3, S2, S1, S0, M, CN,
        input  RESULT, ZERO, ERR, BUSY, DONE, OVF, dbg_state
    );

    modport slave (
        input  START, OP, OPA, OPB, Q,
        output A, B, CPR0, CPR1, CPR2, S3, S2, S1, S0, M, CN,
        output RESULT, ZERO, ERR, BUSY, DONE, OVF, dbg_state
    );
endinterface

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: steps one ALU operation through
// IDLE -> SETUP -> LOAD -> EXEC -> CAP -> WB.
// The operand buses and function selects are driven from copies latched
// when the request is taken. CPR0/CPR1 pulse in LOAD, and CPR2 pulses in
// CAP. The ALU result Q is captured in WB.
// All strobes and status outputs come straight from flops, so they are
// glitch-free. An asynchronous CLR drops them at once.
// Optional feature: define ALU_SEQ_OVF_EN to add signed-overflow
// reporting on OVF. Without it, OVF is tied low.
module alu16_sequencer (
    input  logic             CLK,
    input  logic             CLR,
    alu16_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOAD  = 3'd2,
        EXEC  = 3'd3,
        CAP   = 3'd4,
        WB    = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        reject;

    logic [3:0]  dec_s;
    logic        dec_m;
    logic        dec_cn;
    logic        dec_legal;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  s_q;
    logic        m_q;
    logic        cn_q;

    logic        cpr0_q;
    logic        cpr1_q;
    logic        cpr2_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        zero_q;
    logic [15:0] result_q;

    // Translate the opcode into 74181 function select, mode and carry-in.
    always_comb begin
        dec_s     = 4'b0000;
        dec_m     = 1'b0;
        dec_cn    = 1'b1;
        dec_legal = 1'b1;
        case (bus.OP)
            4'd0: begin dec_s = 4'b1001; dec_m = 1'b0; dec_cn = 1'b1; end
            4'd1: begin dec_s = 4'b0110; dec_m = 1'b0; dec_cn = 1'b0; end
            4'd2: begin dec_s = 4'b1011; dec_m = 1'b1; dec_cn = 1'b1; end
            4'd3: begin dec_s = 4'b1110; dec_m = 1'b1; dec_cn = 1'b1; end
            4'd4: begin dec_s = 4'b0110; dec_m = 1'b1; dec_cn = 1'b1; end
            4'd5: begin dec_s = 4'b0000; dec_m = 1'b1; dec_cn = 1'b1; end
            4'd6: begin dec_s = 4'b1111; dec_m = 1'b1; dec_cn = 1'b1; end
            4'd7: begin dec_s = 4'b0000; dec_m = 1'b0; dec_cn = 1'b0; end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state logic. An illegal opcode is answered from IDLE without
    // starting a sequence.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    if (dec_legal) begin
                        accept     = 1'b1;
                        next_state = SETUP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETUP:   next_state = LOAD;
            LOAD:    next_state = EXEC;
            EXEC:    next_state = CAP;
            CAP:     next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch operands and decoded controls when a request is taken.
    // They hold until the next request.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            a_q  <= 16'h0000;
            b_q  <= 16'h0000;
            s_q  <= 4'b0000;
            m_q  <= 1'b0;
            cn_q <= 1'b1;
        end else if (accept) begin
            a_q  <= bus.OPA;
            b_q  <= bus.OPB;
            s_q  <= dec_s;
            m_q  <= dec_m;
            cn_q <= dec_cn;
        end
    end

    // Strobes and BUSY are registered copies of the state being entered.
    // Each one is high for exactly one full period of its state.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cpr0_q <= 1'b0;
            cpr1_q <= 1'b0;
            cpr2_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cpr0_q <= (next_state == LOAD);
            cpr1_q <= (next_state == LOAD);
            cpr2_q <= (next_state == CAP);
            busy_q <= (next_state != IDLE);
        end
    end

    // Completion status. Capture Q in WB. An illegal request flags ERR
    // and leaves RESULT untouched.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b1;
            result_q <= 16'h0000;
        end else begin
            done_q <= reject || (state == WB);
            if (reject) begin
                err_q <= 1'b1;
            end else if (state == WB) begin
                err_q    <= 1'b0;
                result_q <= bus.Q;
                zero_q   <= (bus.Q == 16'h0000);
            end
        end
    end

`ifdef ALU_SEQ_OVF_EN
    typedef enum logic [1:0] {
        CLS_LOGIC = 2'd0,
        CLS_ADD   = 2'd1,
        CLS_SUB   = 2'd2,
        CLS_INC   = 2'd3
    } cls_t;

    cls_t dec_cls;
    cls_t cls_q;
    logic ovf_d;
    logic ovf_q;

    // Classify the opcode for overflow purposes.
    always_comb begin
        dec_cls = CLS_LOGIC;
        case (bus.OP)
            4'd0:    dec_cls = CLS_ADD;
            4'd1:    dec_cls = CLS_SUB;
            4'd7:    dec_cls = CLS_INC;
            default: dec_cls = CLS_LOGIC;
        endcase
    end

    // Remember the class of the operation in flight.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cls_q <= CLS_LOGIC;
        end else if (accept) begin
            cls_q <= dec_cls;
        end
    end

    // Signed overflow from the operand sign bits and the ALU result sign.
    // INC behaves as ADD with a zero B operand.
    always_comb begin
        ovf_d = 1'b0;
        case (cls_q)
            CLS_ADD: ovf_d = (a_q[15] == b_q[15]) && (bus.Q[15] != a_q[15]);
            CLS_INC: ovf_d = (a_q[15] == 1'b0)    && (bus.Q[15] != a_q[15]);
            CLS_SUB: ovf_d = (a_q[15] != b_q[15]) && (bus.Q[15] != a_q[15]);
            default: ovf_d = 1'b0;
        endcase
    end

    // Overflow flag. Update it on completion and clear it on an illegal
    // request.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ovf_q <= 1'b0;
        end else if (reject) begin
            ovf_q <= 1'b0;
        end else if (state == WB) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.OVF = ovf_q;
`else
    assign bus.OVF = 1'b0;
`endif

    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.S3        = s_q[3];
    assign bus.S2        = s_q[2];
    assign bus.S1        = s_q[1];
    assign bus.S0        = s_q[0];
    assign bus.M         = m_q;
    assign bus.CN        = cn_q;
    assign bus.CPR0      = cpr0_q;
    assign bus.CPR1      = cpr1_q;
    assign bus.CPR2      = cpr2_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.ZERO      = zero_q;
    assign bus.RESULT    = result_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: drives the sequencer against a behavioural 74181 ALU
// datapath. Each request is scored against an opcode-level arithmetic model.
// A cycle-count model gives the expected strobe/BUSY/DONE pattern.
module tb_alu16_sequencer;

    logic CLK = 1'b0;
    logic CLR;

    always #5 CLK = ~CLK;

    alu16_sequencer_if bus ();

    alu16_sequencer dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entry: {ovf, err, zero, result}.
    logic [18:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural 74181 datapath (active-high data).
    // Operand registers load on the rising edges of CPR0/CPR1.
    // The result register loads on the rising edge of CPR2.
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_q;

    function automatic logic [15:0] alu181(input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] s, input logic m, input logic cn);
        logic [15:0] p;
        logic [15:0] r;
        logic [15:0] c;
        c = {15'd0, ~cn};
        if (m) begin
            case (s)
                4'h0: r = ~a;
                4'h1: r = ~(a | b);
                4'h2: r = ~a & b;
                4'h3: r = 16'h0000;
                4'h4: r = ~(a & b);
                4'h5: r = ~b;
                4'h6: r = a ^ b;
                4'h7: r = a & ~b;
                4'h8: r = ~a | b;
                4'h9: r = ~(a ^ b);
                4'hA: r = b;
                4'hB: r = a & b;
                4'hC: r = 16'hFFFF;
                4'hD: r = a | ~b;
                4'hE: r = a | b;
                default: r = a;
            endcase
        end else begin
            case (s)
                4'h0: begin p = a;        r = 16'h0000; end
                4'h1: begin p = a | b;    r = 16'h0000; end
                4'h2: begin p = a | ~b;   r = 16'h0000; end
                4'h3: begin p = 16'hFFFF; r = 16'h0000; end
                4'h4: begin p = a;        r = a & ~b;   end
                4'h5: begin p = a | b;    r = a & ~b;   end
                4'h6: begin p = a;        r = ~b;       end
                4'h7: begin p = a & ~b;   r = 16'hFFFF; end
                4'h8: begin p = a;        r = a & b;    end
                4'h9: begin p = a;        r = b;        end
                4'hA: begin p = a | ~b;   r = a & b;    end
                4'hB: begin p = a & b;    r = 16'hFFFF; end
                4'hC: begin p = a;        r = a;        end
                4'hD: begin p = a | b;    r = a;        end
                4'hE: begin p = a | ~b;   r = a;        end
                default: begin p = a;     r = 16'hFFFF; end
            endcase
            r = p + r + c;
        end
        return r;
    endfunction

    always @(posedge bus.CPR0) alu_a <= bus.A;
    always @(posedge bus.CPR1) alu_b <= bus.B;
    always @(posedge bus.CPR2) alu_q <= alu181(alu_a, alu_b, {bus.S3, bus.S2, bus.S1, bus.S0}, bus.M, bus.CN);

    assign bus.Q = alu_q;

    // Reference model: opcode -> {ovf, result}, using plain arithmetic.
    function automatic logic [16:0] ref_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        int          sa;
        int          sb;
        int          full;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        full = 0;
        v    = 1'b0;
        case (op)
            4'd0: begin r = a + b;  full = sa + sb; end
            4'd1: begin r = a - b;  full = sa - sb; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: r = a;
            default: begin r = a + 16'd1; full = sa + 1; end
        endcase
`ifdef ALU_SEQ_OVF_EN
        if (op == 4'd0 || op == 4'd1 || op == 4'd7) v = (full > 32767) || (full < -32768);
`else
        v = 1'b0;
`endif
        return {v, r};
    endfunction

    // Control lines the ALU should see for each legal opcode: {S3..S0, M, CN}.
    function automatic logic [5:0] ref_sel(input logic [3:0] op);
        case (op)
            4'd0: return 6'b1001_0_1;
            4'd1: return 6'b0110_0_0;
            4'd2: return 6'b1011_1_1;
            4'd3: return 6'b1110_1_1;
            4'd4: return 6'b0110_1_1;
            4'd5: return 6'b0000_1_1;
            4'd6: return 6'b1111_1_1;
            default: return 6'b0000_0_0;
        endcase
    endfunction

    // Cycle model. seq_cnt counts the cycles since a legal request was taken:
    // 1..5 is busy, 6 is the DONE cycle. ill_pend marks the DONE cycle after
    // an illegal request.
    int          seq_cnt   = 0;
    logic        ill_pend  = 1'b0;
    logic [3:0]  lat_op    = 4'd0;
    logic [15:0] lat_a     = 16'h0000;
    logic [15:0] lat_b     = 16'h0000;
    logic [15:0] last_res  = 16'h0000;
    logic        last_zero = 1'b1;

    always @(negedge CLK) begin
        logic [4:0]  exp_ctl;
        logic [16:0] r;
        if (CLR) begin
            seq_cnt   = 0;
            ill_pend  = 1'b0;
            last_res  = 16'h0000;
            last_zero = 1'b1;
            exp_q.delete();
        end else begin
            exp_ctl = {(seq_cnt >= 1 && seq_cnt <= 5), (seq_cnt == 2), (seq_cnt == 2),
                       (seq_cnt == 4), (seq_cnt == 6) || ill_pend};
            check("ctl_busy_cpr0_cpr1_cpr2_done",
                  64'({bus.BUSY, bus.CPR0, bus.CPR1, bus.CPR2, bus.DONE}), 64'(exp_ctl));
            if (seq_cnt >= 1 && seq_cnt <= 5) begin
                check("bus_hold_a_b_sel",
                      64'({bus.A, bus.B, bus.S3, bus.S2, bus.S1, bus.S0, bus.M, bus.CN}),
                      64'({lat_a, lat_b, ref_sel(lat_op)}));
            end
            ill_pend = 1'b0;
            if (seq_cnt >= 1 && seq_cnt <= 5) begin
                seq_cnt++;
            end else begin
                seq_cnt = 0;
                if (bus.START) begin
                    if (bus.OP < 4'd8) begin
                        seq_cnt   = 1;
                        lat_op    = bus.OP;
                        lat_a     = bus.OPA;
                        lat_b     = bus.OPB;
                        r         = ref_op(bus.OP, bus.OPA, bus.OPB);
                        last_res  = r[15:0];
                        last_zero = (r[15:0] == 16'h0000);
                        exp_q.push_back({r[16], 1'b0, last_zero, last_res});
                    end else begin
                        ill_pend = 1'b1;
                        exp_q.push_back({1'b0, 1'b1, last_zero, last_res});
                    end
                end
            end
        end
    end

    // Monitor: score every DONE against the oldest expected response.
    always @(negedge CLK) begin
        logic [18:0] e;
        if (!CLR && bus.DONE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("done_resp_ovf_err_zero_result",
                      64'({bus.OVF, bus.ERR, bus.ZERO, bus.RESULT}), 64'(e));
            end
        end
    end

    task automatic reset_check(input string name);
        check(name,
              64'({bus.A, bus.B, bus.S3, bus.S2, bus.S1, bus.S0, bus.M, bus.CN,
                   bus.CPR0, bus.CPR1, bus.CPR2, bus.RESULT, bus.ZERO, bus.ERR,
                   bus.BUSY, bus.DONE, bus.OVF}),
              64'({16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b1, 3'b000, 16'h0000,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    endtask

    // Called 1 time unit after a rising edge with the DUT idle. Returns one
    // time unit after the edge that follows the DONE cycle.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.OPA   = a;
        bus.OPB   = b;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        repeat (6) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        int done_cnt;
        alu_a     = 16'h0000;
        alu_b     = 16'h0000;
        alu_q     = 16'h0000;
        bus.START = 1'b0;
        bus.OP    = 4'd0;
        bus.OPA   = 16'h0000;
        bus.OPB   = 16'h0000;
        CLR       = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        reset_check("reset_values");
        CLR = 1'b0;
        @(posedge CLK);
        #1;

        issue(4'd0, 16'h1234, 16'h0FF0);
        check("add_result", 64'({bus.RESULT, bus.ZERO}), 64'({16'h2224, 1'b0}));

        issue(4'd1, 16'h00FF, 16'h00FF);
        check("sub_result_zero", 64'({bus.RESULT, bus.ZERO}), 64'({16'h0000, 1'b1}));

        issue(4'd0, 16'h1234, 16'h0FF0);
        issue(4'd9, 16'hAAAA, 16'h5555);
        check("illegal_err_result_busy", 64'({bus.ERR, bus.RESULT, bus.BUSY}),
              64'({1'b1, 16'h2224, 1'b0}));
        issue(4'd4, 16'hFF00, 16'h0FF0);
        check("err_cleared", 64'({bus.ERR, bus.RESULT}), 64'({1'b0, 16'hF0F0}));

        // START held high: back-to-back ANDs, one every 6 cycles.
        done_cnt  = 0;
        bus.START = 1'b1;
        bus.OP    = 4'd2;
        bus.OPA   = 16'hF0F0;
        bus.OPB   = 16'h3C3C;
        repeat (24) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) done_cnt++;
        end
        bus.START = 1'b0;
        check("continuous_done_count", 64'(done_cnt), 64'(4));
        check("continuous_result", 64'(bus.RESULT), 64'(16'h3030));
        repeat (7) begin
            @(posedge CLK);
            #1;
        end

        // Reset in EXEC, then a normal operation.
        bus.START = 1'b1;
        bus.OP    = 4'd3;
        bus.OPA   = 16'h1200;
        bus.OPB   = 16'h0034;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        check("busy_before_clr", 64'(bus.BUSY), 64'(1));
        CLR = 1'b1;
        #1;
        reset_check("clr_mid_sequence");
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        @(posedge CLK);
        #1;
        issue(4'd7, 16'h00FF, 16'h0000);
        check("after_clr_inc", 64'(bus.RESULT), 64'(16'h0100));

`ifdef ALU_SEQ_OVF_EN
        issue(4'd0, 16'h7FFF, 16'h0001);
        check("ovf_add", 64'({bus.RESULT, bus.OVF}), 64'({16'h8000, 1'b1}));
        issue(4'd1, 16'h8000, 16'h0001);
        check("ovf_sub", 64'({bus.RESULT, bus.OVF}), 64'({16'h7FFF, 1'b1}));
        issue(4'd12, 16'h0000, 16'h0000);
        check("ovf_clr_illegal", 64'(bus.OVF), 64'(0));
`else
        issue(4'd0, 16'h7FFF, 16'h0001);
        check("ovf_tied_low", 64'({bus.RESULT, bus.OVF}), 64'({16'h8000, 1'b0}));
`endif

        // Random traffic, including requests while busy and illegal opcodes.
        repeat (600) begin
            bus.START = ($urandom_range(0, 2) != 0);
            bus.OP    = 4'($urandom_range(0, 9));
            bus.OPA   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            bus.OPB   = ($urandom_range(0, 7) == 0) ? bus.OPA : 16'($urandom);
            if ($urandom_range(0, 15) == 0) bus.OPA = 16'h7FFF;
            @(posedge CLK);
            #1;
        end
        bus.START = 1'b0;
        repeat (10) begin
            @(posedge CLK);
            #1;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
